// File: rtl/bm_mem_arb_if.sv
// Bundle between the bitmatrix SRAM arbiter, its two requesters (bm_cntl, host) and the SRAM.
// The slave modport is the arbiter's view; master is the requester/SRAM side.
interface bm_mem_arb_if #(
    parameter int unsigned W            = 4,
    parameter int unsigned K_MAX        = 128,
    parameter int unsigned BM_MEM_DEPTH = 128
);
    localparam int unsigned BM_COL_W      = W * W * K_MAX;
    localparam int unsigned BM_MEM_ADDR_W = $clog2(BM_MEM_DEPTH);

    logic                     eng_busy;

    logic                     bm_cntl_rd_rq;
    logic [BM_MEM_ADDR_W-1:0] bm_cntl_rd_addr;
    logic                     bm_cntl_rd_gnt;
    logic [BM_COL_W-1:0]      bm_cntl_rd_data;
    logic                     bm_cntl_rd_data_val;

    logic                     host_rd_rq;
    logic                     host_wr_rq;
    logic [BM_MEM_ADDR_W-1:0] host_addr;
    logic [BM_COL_W-1:0]      host_wr_data;
    logic                     host_gnt;
    logic [BM_COL_W-1:0]      host_rd_data;
    logic                     host_rd_data_val;
    logic                     host_wr_locked;

    logic                     mem_en;
    logic                     mem_wr_en;
    logic [BM_MEM_ADDR_W-1:0] mem_addr;
    logic [BM_COL_W-1:0]      mem_wr_data;
    logic [BM_COL_W-1:0]      mem_rd_data;

    modport slave (
        input  eng_busy,
        input  bm_cntl_rd_rq, bm_cntl_rd_addr,
        output bm_cntl_rd_gnt, bm_cntl_rd_data, bm_cntl_rd_data_val,
        input  host_rd_rq, host_wr_rq, host_addr, host_wr_data,
        output host_gnt, host_rd_data, host_rd_data_val, host_wr_locked,
        output mem_en, mem_wr_en, mem_addr, mem_wr_data,
        input  mem_rd_data
    );

    modport master (
        output eng_busy,
        output bm_cntl_rd_rq, bm_cntl_rd_addr,
        input  bm_cntl_rd_gnt, bm_cntl_rd_data, bm_cntl_rd_data_val,
        output host_rd_rq, host_wr_rq, host_addr, host_wr_data,
        input  host_gnt, host_rd_data, host_rd_data_val, host_wr_locked,
        input  mem_en, mem_wr_en, mem_addr, mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/bm_mem_arb.sv
// Arbiter/sequencer for the single-port bitmatrix SRAM: engine column reads win over host
// access, a starvation counter guarantees host progress, host writes are locked while the engine runs.
module bm_mem_arb #(
    parameter int unsigned W             = 4,
    parameter int unsigned K_MAX         = 128,
    parameter int unsigned BM_COL_W      = W * W * K_MAX,
    parameter int unsigned BM_MEM_DEPTH  = 128,
    parameter int unsigned BM_MEM_ADDR_W = $clog2(BM_MEM_DEPTH),
    parameter int unsigned RD_LAT        = 1,
    parameter int unsigned STARVE_MAX    = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         eng_rstn,
    bm_mem_arb_if.slave  bus
);
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] ST_OPEN   = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_CNTL = 2'd1;
    localparam logic [1:0] TAG_HOST = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [STARVE_W-1:0]      starve_q, starve_d;
    logic [1:0]               tag_q [RD_LAT];
    logic [1:0]               tag_d [RD_LAT];
    logic [1:0]               new_tag;

    logic                     host_rd_sel;
    logic                     host_wr_sel;
    logic                     wr_lock;
    logic                     host_can;
    logic                     host_forced;
    logic                     host_gnt;
    logic                     cntl_gnt;
    logic                     pipe_empty;
    logic [BM_MEM_ADDR_W-1:0] addr_sel;
    logic [BM_COL_W-1:0]      wr_data_sel;

    // Request decode and grant. Everything is forced idle while rstn is low.
    always_comb begin
        host_rd_sel = bus.host_rd_rq;
        host_wr_sel = bus.host_wr_rq && !bus.host_rd_rq;
        wr_lock     = (state_q != ST_OPEN) || bus.eng_busy;
        host_can    = rstn && (host_rd_sel || (host_wr_sel && !wr_lock));
        host_forced = (starve_q == STARVE_W'(STARVE_MAX));
        host_gnt    = host_can && (!bus.bm_cntl_rd_rq || host_forced);
        cntl_gnt    = rstn && bus.bm_cntl_rd_rq && !host_gnt;
    end

    always_comb begin
        addr_sel    = '0;
        wr_data_sel = '0;
        if (cntl_gnt) begin
            addr_sel = bus.bm_cntl_rd_addr;
        end else if (host_gnt) begin
            addr_sel = bus.host_addr;
            if (host_wr_sel) begin
                wr_data_sel = bus.host_wr_data;
            end
        end
    end

    always_comb begin
        pipe_empty = 1'b1;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            if (tag_q[i] != TAG_NONE) begin
                pipe_empty = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OPEN:   if (bus.eng_busy) state_d = ST_LOCKED;
            ST_LOCKED: if (!bus.eng_busy) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (bus.eng_busy) begin
                    state_d = ST_LOCKED;
                end else if (pipe_empty) begin
                    state_d = ST_OPEN;
                end
            end
            default:   state_d = ST_OPEN;
        endcase
    end

    // Counts cycles a grantable host request lost to the engine; saturates at the limit.
    always_comb begin
        starve_d = starve_q;
        if (!eng_rstn || host_gnt || !host_can) begin
            starve_d = '0;
        end else if (starve_q < STARVE_W'(STARVE_MAX)) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // Owner-tag pipeline; an engine soft reset strips every engine tag, including the new one.
    always_comb begin
        new_tag = TAG_NONE;
        if (cntl_gnt) begin
            new_tag = TAG_CNTL;
        end else if (host_gnt && host_rd_sel) begin
            new_tag = TAG_HOST;
        end
        tag_d[0] = new_tag;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            tag_d[i] = tag_q[i-1];
        end
        for (int i = 0; i < int'(RD_LAT); i++) begin
            if (!eng_rstn && (tag_d[i] == TAG_CNTL)) begin
                tag_d[i] = TAG_NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_OPEN;
            starve_q <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                tag_q[i] <= TAG_NONE;
            end
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    always_comb begin
        bus.bm_cntl_rd_gnt      = cntl_gnt;
        bus.host_gnt            = host_gnt;
        bus.mem_en              = cntl_gnt || host_gnt;
        bus.mem_wr_en           = host_gnt && host_wr_sel;
        bus.mem_addr            = addr_sel;
        bus.mem_wr_data         = wr_data_sel;
        bus.bm_cntl_rd_data     = bus.mem_rd_data;
        bus.host_rd_data        = bus.mem_rd_data;
        bus.bm_cntl_rd_data_val = rstn && eng_rstn && (tag_q[RD_LAT-1] == TAG_CNTL);
        bus.host_rd_data_val    = rstn && (tag_q[RD_LAT-1] == TAG_HOST);
        bus.host_wr_locked      = rstn && host_wr_sel && wr_lock;
    end
endmodule

// File: tb/tb_bm_mem_arb.sv
// Self-checking bench for bm_mem_arb: directed scenarios plus random traffic, checked by a
// cycle-level reference model feeding read-data scoreboards popped by an independent monitor.
module tb_bm_mem_arb;
    localparam int unsigned W          = 4;
    localparam int unsigned K_MAX      = 2;
    localparam int unsigned COL_W      = W * W * K_MAX;
    localparam int unsigned DEPTH      = 128;
    localparam int unsigned AW         = $clog2(DEPTH);
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned STARVE_MAX = 4;

    typedef struct packed {
        int               due;
        logic [COL_W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    logic eng_rstn;

    bm_mem_arb_if #(.W(W), .K_MAX(K_MAX), .BM_MEM_DEPTH(DEPTH)) bus ();

    bm_mem_arb #(
        .W(W), .K_MAX(K_MAX), .BM_MEM_DEPTH(DEPTH), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .eng_rstn(eng_rstn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // SRAM behavioural model with RD_LAT read latency
    logic [COL_W-1:0] sram [DEPTH];
    logic [COL_W-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        for (int i = int'(RD_LAT) - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= '0;
        if (bus.mem_en) begin
            if (bus.mem_wr_en) sram[bus.mem_addr] <= bus.mem_wr_data;
            else rd_pipe[0] <= sram[bus.mem_addr];
        end
    end
    assign bus.mem_rd_data = rd_pipe[RD_LAT-1];

    // Reference model: expected memory contents, arbitration rules, lock phase
    logic [COL_W-1:0] ref_mem [DEPTH];
    exp_t cntl_q[$];
    exp_t host_q[$];
    int   phase  = 0;   // 0 open, 1 engine busy, 2 waiting for reads to drain
    int   starve = 0;
    bit   m_h_rd, m_h_wr, m_wr_ok, m_h_can, m_host, m_cntl, m_wr;
    int   m_outstanding;

    always @(negedge clk) begin
        if (!rstn) begin
            chk("rst_cntl_gnt", 64'(bus.bm_cntl_rd_gnt), 64'(0));
            chk("rst_host_gnt", 64'(bus.host_gnt), 64'(0));
            chk("rst_mem_en", 64'(bus.mem_en), 64'(0));
            chk("rst_mem_wr_en", 64'(bus.mem_wr_en), 64'(0));
            chk("rst_wr_locked", 64'(bus.host_wr_locked), 64'(0));
            chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
            chk("rst_mem_wr_data", 64'(bus.mem_wr_data), 64'(0));
            phase  = 0;
            starve = 0;
            cntl_q.delete();
            host_q.delete();
        end else begin
            m_h_rd  = bus.host_rd_rq;
            m_h_wr  = bus.host_wr_rq && !bus.host_rd_rq;
            m_wr_ok = (phase == 0) && !bus.eng_busy;
            m_h_can = m_h_rd || (m_h_wr && m_wr_ok);
            m_host  = m_h_can && (!bus.bm_cntl_rd_rq || starve == int'(STARVE_MAX));
            m_cntl  = bus.bm_cntl_rd_rq && !m_host;
            m_wr    = m_host && m_h_wr;
            chk("cntl_gnt", 64'(bus.bm_cntl_rd_gnt), 64'(m_cntl));
            chk("host_gnt", 64'(bus.host_gnt), 64'(m_host));
            chk("mem_en", 64'(bus.mem_en), 64'(m_cntl || m_host));
            chk("mem_wr_en", 64'(bus.mem_wr_en), 64'(m_wr));
            chk("host_wr_locked", 64'(bus.host_wr_locked), 64'(m_h_wr && !m_wr_ok));
            if (m_cntl) chk("mem_addr_cntl", 64'(bus.mem_addr), 64'(bus.bm_cntl_rd_addr));
            if (m_host) chk("mem_addr_host", 64'(bus.mem_addr), 64'(bus.host_addr));
            if (m_wr) chk("mem_wr_data", 64'(bus.mem_wr_data), 64'(bus.host_wr_data));
            m_outstanding = cntl_q.size() + host_q.size();
            case (phase)
                0: if (bus.eng_busy) phase = 1;
                1: if (!bus.eng_busy) phase = 2;
                default: if (bus.eng_busy) phase = 1; else if (m_outstanding == 0) phase = 0;
            endcase
            if (!eng_rstn || m_host || !m_h_can) starve = 0;
            else if (starve < int'(STARVE_MAX)) starve++;
            if (m_cntl) cntl_q.push_back('{cyc + int'(RD_LAT), ref_mem[bus.bm_cntl_rd_addr]});
            if (m_host && m_h_rd) host_q.push_back('{cyc + int'(RD_LAT), ref_mem[bus.host_addr]});
            if (m_wr) ref_mem[bus.host_addr] = bus.host_wr_data;
            if (!eng_rstn) cntl_q.delete();
        end
    end

    // Monitor: compares returned read data against the scoreboard queues
    exp_t mon_e;
    bit   mon_exp;
    always @(negedge clk) begin
        #2;
        mon_exp = (cntl_q.size() != 0) && (cntl_q[0].due == cyc);
        chk("cntl_rd_data_val", 64'(bus.bm_cntl_rd_data_val), 64'(mon_exp));
        if (mon_exp) begin
            mon_e = cntl_q.pop_front();
            if (bus.bm_cntl_rd_data_val) chk("cntl_rd_data", 64'(bus.bm_cntl_rd_data), 64'(mon_e.data));
        end
        mon_exp = (host_q.size() != 0) && (host_q[0].due == cyc);
        chk("host_rd_data_val", 64'(bus.host_rd_data_val), 64'(mon_exp));
        if (mon_exp) begin
            mon_e = host_q.pop_front();
            if (bus.host_rd_data_val) chk("host_rd_data", 64'(bus.host_rd_data), 64'(mon_e.data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.bm_cntl_rd_rq = 1'b0;
        bus.host_rd_rq    = 1'b0;
        bus.host_wr_rq    = 1'b0;
    endtask

    int cnt_a, cnt_b, val_cyc, wr_cyc;
    logic [COL_W-1:0] data_a;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            data_a = $urandom;
            sram[i] = data_a;
            ref_mem[i] = data_a;
        end
        for (int i = 0; i < int'(RD_LAT); i++) rd_pipe[i] = '0;

        // Reset with every request high
        rstn = 1'b0;
        eng_rstn = 1'b1;
        bus.eng_busy = 1'b0;
        bus.bm_cntl_rd_rq = 1'b1;
        bus.host_rd_rq = 1'b1;
        bus.host_wr_rq = 1'b1;
        bus.bm_cntl_rd_addr = 7'd1;
        bus.host_addr = 7'd2;
        bus.host_wr_data = 32'h1111_2222;
        repeat (3) tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("reset_release_cntl_first", 64'(bus.bm_cntl_rd_gnt), 64'(1));
        tick();
        idle();
        repeat (4) tick();

        // Host write then read of address 5
        data_a = 32'hA5C3_9E01;
        bus.host_wr_rq = 1'b1;
        bus.host_addr = 7'd5;
        bus.host_wr_data = data_a;
        tick();
        bus.host_wr_rq = 1'b0;
        bus.host_rd_rq = 1'b1;
        tick();
        bus.host_rd_rq = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.host_rd_data_val && cnt_a == 0) begin
                cnt_a = 1;
                chk("wr_then_rd_data", 64'(bus.host_rd_data), 64'(data_a));
            end
            tick();
        end
        chk("wr_then_rd_val_seen", 64'(cnt_a), 64'(1));

        // Starvation: host wins every 5th cycle
        bus.bm_cntl_rd_rq = 1'b1;
        bus.host_rd_rq = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            cnt_a += int'(bus.host_gnt);
            tick();
        end
        chk("starve_host_gnt_count", 64'(cnt_a), 64'(5));
        idle();
        repeat (4) tick();

        // Lock: writes refused while busy, granted only after the in-flight read drains
        bus.eng_busy = 1'b1;
        bus.host_wr_rq = 1'b1;
        bus.host_addr = 7'd7;
        bus.host_wr_data = 32'h0BAD_F00D;
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cnt_a += int'(bus.mem_wr_en);
            cnt_b += int'(bus.host_wr_locked);
            tick();
        end
        chk("lock_no_writes", 64'(cnt_a), 64'(0));
        chk("lock_locked_level", 64'(cnt_b), 64'(10));
        bus.host_rd_rq = 1'b1;
        tick();
        bus.host_rd_rq = 1'b0;
        bus.eng_busy = 1'b0;
        val_cyc = -1;
        wr_cyc = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.host_rd_data_val) val_cyc = cyc;
            if (bus.mem_wr_en && wr_cyc < 0) wr_cyc = cyc;
            tick();
        end
        chk("lock_wr_after_last_val", 64'(wr_cyc > val_cyc && val_cyc >= 0), 64'(1));
        idle();
        repeat (3) tick();

        // Engine soft reset drops the engine read but not the host read
        bus.bm_cntl_rd_rq = 1'b1;
        bus.bm_cntl_rd_addr = 7'd9;
        tick();
        bus.bm_cntl_rd_rq = 1'b0;
        bus.host_rd_rq = 1'b1;
        bus.host_addr = 7'd10;
        eng_rstn = 1'b0;
        tick();
        bus.host_rd_rq = 1'b0;
        eng_rstn = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cnt_a += int'(bus.bm_cntl_rd_data_val);
            cnt_b += int'(bus.host_rd_data_val);
            tick();
        end
        chk("eng_rstn_cntl_val_dropped", 64'(cnt_a), 64'(0));
        chk("eng_rstn_host_val_kept", 64'(cnt_b), 64'(1));

        // Simultaneous host read and write: read wins
        bus.host_rd_rq = 1'b1;
        bus.host_wr_rq = 1'b1;
        bus.host_addr = 7'd3;
        @(negedge clk);
        chk("rd_wins_gnt", 64'(bus.host_gnt), 64'(1));
        chk("rd_wins_no_wr", 64'(bus.mem_wr_en), 64'(0));
        tick();
        idle();
        repeat (4) tick();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.bm_cntl_rd_rq = ($urandom_range(0, 99) < 55);
            bus.host_rd_rq = ($urandom_range(0, 99) < 35);
            bus.host_wr_rq = ($urandom_range(0, 99) < 45);
            bus.bm_cntl_rd_addr = 7'($urandom_range(0, 15));
            bus.host_addr = 7'($urandom_range(0, 15));
            bus.host_wr_data = $urandom;
            if ($urandom_range(0, 39) == 0) bus.eng_busy = !bus.eng_busy;
            eng_rstn = ($urandom_range(0, 49) != 0);
            rstn = ($urandom_range(0, 499) != 0);
            tick();
        end
        idle();
        rstn = 1'b1;
        eng_rstn = 1'b1;
        bus.eng_busy = 1'b0;
        repeat (10) tick();
        chk("scoreboard_empty", 64'(cntl_q.size() + host_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
